// File: rtl/gpu_instr_unpack.sv
// GPU instruction unpacker: splits prefetched longwords into 16-bit opcodes
// with byte PCs, handling jump flushes, odd-halfword targets and stale fetches.
module gpu_instr_unpack #(
  parameter int unsigned AW    = 23,
  parameter int unsigned DEPTH = 3
) (
  input  logic          sys_clk,
  input  logic          resetl,
  input  logic [31:0]   pf_data,
  input  logic [AW-1:0] pf_addr,
  input  logic          pf_valid,
  output logic          pf_ready,
  input  logic          flush,
  input  logic [AW-1:0] flush_pc,
  output logic [15:0]   op_data,
  output logic [AW-1:0] op_pc,
  output logic          op_valid,
  input  logic          op_ready,
  output logic          stale,
  output logic [1:0]    buf_cnt
);

  localparam int unsigned HW = 16;

  logic [HW-1:0] buf_q [0:2];
  logic [HW-1:0] buf_d [0:2];
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] op_pc_q, op_pc_d;
  logic [AW-1:0] exp_addr_q, exp_addr_d;
  logic          skip_q, skip_d;
  logic          stale_q, stale_d;

  logic pop, accept, addr_match;
  logic unused_bits;

  assign unused_bits = ^{flush_pc[0], pf_addr[1:0]};

  // Room for a full longword only when at most one halfword is buffered.
  assign pf_ready   = resetl & (cnt_q <= 2'(DEPTH - 2));
  assign op_valid   = (cnt_q != 2'd0);
  assign pop        = op_valid & op_ready & ~flush;
  assign accept     = pf_valid & pf_ready & ~flush;
  assign addr_match = (pf_addr[AW-1:2] == exp_addr_q[AW-1:2]);

  assign op_data = buf_q[0];
  assign op_pc   = op_pc_q;
  assign stale   = stale_q;
  assign buf_cnt = cnt_q;

  // Next-state: flush wins; otherwise pop shifts the FIFO, then pushes append.
  always_comb begin
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    op_pc_d    = op_pc_q;
    exp_addr_d = exp_addr_q;
    skip_d     = skip_q;
    stale_d    = 1'b0;
    if (flush) begin
      cnt_d      = 2'd0;
      op_pc_d    = {flush_pc[AW-1:1], 1'b0};
      exp_addr_d = {flush_pc[AW-1:2], 2'b00};
      skip_d     = flush_pc[1];
    end else begin
      if (pop) begin
        buf_d[0] = buf_q[1];
        buf_d[1] = buf_q[2];
        cnt_d    = cnt_q - 2'd1;
        op_pc_d  = op_pc_q + AW'(2);
      end
      if (accept) begin
        if (addr_match) begin
          if (cnt_d == 2'd0) begin
            if (skip_q) begin
              buf_d[0] = pf_data[15:0];
            end else begin
              buf_d[0] = pf_data[31:16];
              buf_d[1] = pf_data[15:0];
            end
          end else begin
            if (skip_q) begin
              buf_d[1] = pf_data[15:0];
            end else begin
              buf_d[1] = pf_data[31:16];
              buf_d[2] = pf_data[15:0];
            end
          end
          cnt_d      = cnt_d + (skip_q ? 2'd1 : 2'd2);
          skip_d     = 1'b0;
          exp_addr_d = exp_addr_q + AW'(4);
        end else begin
          stale_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!resetl) begin
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
      buf_q[2]   <= '0;
      cnt_q      <= 2'd0;
      op_pc_q    <= '0;
      exp_addr_q <= '0;
      skip_q     <= 1'b0;
      stale_q    <= 1'b0;
    end else begin
      buf_q[0]   <= buf_d[0];
      buf_q[1]   <= buf_d[1];
      buf_q[2]   <= buf_d[2];
      cnt_q      <= cnt_d;
      op_pc_q    <= op_pc_d;
      exp_addr_q <= exp_addr_d;
      skip_q     <= skip_d;
      stale_q    <= stale_d;
    end
  end

endmodule

// File: tb/tb_gpu_instr_unpack.sv
// Directed bench for gpu_instr_unpack: a reference model fills a scoreboard of
// expected opcodes/PCs that is compared against the DUT every cycle.
module tb_gpu_instr_unpack;

  localparam int unsigned AW = 23;

  typedef struct packed {
    logic [15:0]   d;
    logic [AW-1:0] pc;
  } op_t;

  logic          sys_clk = 1'b0;
  logic          resetl;
  logic [31:0]   pf_data;
  logic [AW-1:0] pf_addr;
  logic          pf_valid;
  logic          pf_ready;
  logic          flush;
  logic [AW-1:0] flush_pc;
  logic [15:0]   op_data;
  logic [AW-1:0] op_pc;
  logic          op_valid;
  logic          op_ready;
  logic          stale;
  logic [1:0]    buf_cnt;

  int errors = 0;
  int checks = 0;

  op_t           q[$];
  logic [AW-1:0] m_exp   = '0;
  logic          m_skip  = 1'b0;
  logic          m_stale = 1'b0;
  logic          acc_seen = 1'b0;

  always #5 sys_clk = ~sys_clk;

  gpu_instr_unpack dut (
    .sys_clk  (sys_clk),
    .resetl   (resetl),
    .pf_data  (pf_data),
    .pf_addr  (pf_addr),
    .pf_valid (pf_valid),
    .pf_ready (pf_ready),
    .flush    (flush),
    .flush_pc (flush_pc),
    .op_data  (op_data),
    .op_pc    (op_pc),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .stale    (stale),
    .buf_cnt  (buf_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare DUT state to the model mid-cycle, then advance the model over the next edge.
  task automatic tick();
    logic acc, pop;
    op_t  e;
    @(negedge sys_clk);
    chk("buf_cnt", 32'(buf_cnt), 32'(q.size()));
    chk("op_valid", 32'(op_valid), 32'(q.size() != 0));
    chk("pf_ready", 32'(pf_ready), 32'(resetl && q.size() <= 1));
    chk("stale", 32'(stale), 32'(m_stale));
    if (q.size() != 0) begin
      chk("op_data", 32'(op_data), 32'(q[0].d));
      chk("op_pc", 32'(op_pc), 32'(q[0].pc));
    end
    acc_seen = 1'b0;
    m_stale  = 1'b0;
    if (!resetl) begin
      q.delete();
      m_exp  = '0;
      m_skip = 1'b0;
    end else if (flush) begin
      q.delete();
      m_exp  = {flush_pc[AW-1:2], 2'b00};
      m_skip = flush_pc[1];
    end else begin
      pop = (q.size() != 0) && op_ready;
      acc = pf_valid && (q.size() <= 1);
      if (pop) void'(q.pop_front());
      if (acc) begin
        acc_seen = 1'b1;
        if (pf_addr[AW-1:2] == m_exp[AW-1:2]) begin
          if (!m_skip) begin
            e.d = pf_data[31:16]; e.pc = m_exp;
            q.push_back(e);
          end
          e.d = pf_data[15:0]; e.pc = m_exp + AW'(2);
          q.push_back(e);
          m_skip = 1'b0;
          m_exp  = m_exp + AW'(4);
        end else begin
          m_stale = 1'b1;
        end
      end
    end
    @(posedge sys_clk);
    #1;
  endtask

  // Present one longword until it is taken, with a bounded wait.
  task automatic push_lw(input logic [AW-1:0] a, input logic [31:0] d);
    bit done = 0;
    pf_valid = 1'b1; pf_addr = a; pf_data = d;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = acc_seen;
    end
    pf_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic do_flush(input logic [AW-1:0] pc);
    flush = 1'b1; flush_pc = pc;
    tick();
    flush = 1'b0;
  endtask

  task automatic drain(input int n);
    op_ready = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    resetl = 1'b0; pf_data = '0; pf_addr = '0; pf_valid = 1'b0;
    flush = 1'b0; flush_pc = '0; op_ready = 1'b0;
    @(posedge sys_clk); #1;
    tick();
    chk("rst_op_pc", 32'(op_pc), 32'd0);
    chk("rst_op_data", 32'(op_data), 32'd0);
    chk("rst_pf_ready", 32'(pf_ready), 32'd0);
    resetl = 1'b1;

    // Basic split, big-endian order
    do_flush(23'h000100);
    push_lw(23'h000100, 32'h12345678);
    tick();
    chk("t1_cnt2", 32'(buf_cnt), 32'd2);
    drain(3);
    op_ready = 1'b0;

    // Odd-halfword jump target skips the upper half
    do_flush(23'h000202);
    push_lw(23'h000200, 32'hAAAABBBB);
    tick();
    chk("t2_cnt1", 32'(buf_cnt), 32'd1);
    chk("t2_op", 32'(op_data), 32'h0000BBBB);
    chk("t2_pc", 32'(op_pc), 32'h00000202);
    push_lw(23'h000204, 32'h11112222);
    drain(4);

    // Stall then stream back-to-back
    op_ready = 1'b0;
    push_lw(23'h000208, 32'h33334444);
    pf_valid = 1'b1; pf_addr = 23'h00020C; pf_data = 32'h55556666;
    tick(); tick(); tick();
    chk("t3_hold_data", 32'(op_data), 32'h00003333);
    chk("t3_hold_pc", 32'(op_pc), 32'h00000208);
    op_ready = 1'b1;
    push_lw(23'h00020C, 32'h55556666);
    push_lw(23'h000210, 32'h77778888);
    push_lw(23'h000214, 32'h9999AAAA);
    drain(6);

    // Stale longword dropped, then correct one accepted
    op_ready = 1'b0;
    do_flush(23'h000300);
    push_lw(23'h000400, 32'hDEADBEEF);
    tick();
    tick();
    push_lw(23'h000300, 32'hCAFEF00D);
    drain(3);

    // Address wrap at 2^AW
    do_flush(23'h7FFFFC);
    push_lw(23'h7FFFFC, 32'h01020304);
    push_lw(23'h000000, 32'h05060708);
    drain(5);

    // Flush voids simultaneous handshakes; bit 0 of flush_pc is ignored
    op_ready = 1'b0;
    do_flush(23'h000600);
    push_lw(23'h000600, 32'h0A0B0C0D);
    pf_valid = 1'b1; pf_addr = 23'h000604; pf_data = 32'h0E0F1011;
    op_ready = 1'b1;
    do_flush(23'h000501);
    pf_valid = 1'b0; op_ready = 1'b0;
    chk("fl_cnt", 32'(buf_cnt), 32'd0);
    chk("fl_valid", 32'(op_valid), 32'd0);
    chk("fl_pc", 32'(op_pc), 32'h00000500);
    push_lw(23'h000500, 32'h12121313);
    tick();

    // Reset mid-stream
    resetl = 1'b0;
    tick();
    chk("mr_op_pc", 32'(op_pc), 32'd0);
    chk("mr_op_data", 32'(op_data), 32'd0);
    chk("mr_cnt", 32'(buf_cnt), 32'd0);
    chk("mr_pf_ready", 32'(pf_ready), 32'd0);
    tick();
    resetl = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gpu_instr_unpack.md
Name: gpu_instr_unpack

Overview:
- Consumer end of the GPU prefetch path.
- The prefetcher generates 23-bit longword fetch addresses and pushes fetched 32-bit longwords. This block accepts them, splits each into two 16-bit opcodes (big-endian: bits 31:16 first), and presents one opcode per cycle to the instruction decoder with its byte PC.
- Handles jump flushes, odd-halfword jump targets, and discards stale longwords whose address does not match the expected fetch address.

Parameters:
- AW, 23, address width in bytes; all PC/address arithmetic is modulo 2^AW.
- DEPTH, 3, halfword buffer capacity (fixed at 3; other values unsupported).

Ports:
- sys_clk  in  1  system clock; all state updates on rising edge.
- resetl  in  1  synchronous active-low reset.
- pf_data  in  32  longword from prefetch queue.
- pf_addr  in  AW  byte address of pf_data; bits 1:0 are always 0.
- pf_valid  in  1  pf_data/pf_addr valid.
- pf_ready  out  1  block can accept a longword this cycle.
- flush  in  1  jump taken; discard buffer and restart at flush_pc.
- flush_pc  in  AW  new byte PC; bit 0 ignored (treated as 0).
- op_data  out  16  current opcode.
- op_pc  out  AW  byte address of op_data.
- op_valid  out  1  op_data valid.
- op_ready  in  1  decoder consumes op_data.
- stale  out  1  one-cycle pulse: a longword was dropped on address mismatch.
- buf_cnt  out  2  halfwords currently buffered (0..3).

Behaviour:
- Reset (resetl=0 at clock edge):
  - buf_cnt=0, op_valid=0, op_pc=0, op_data=0, stale=0, skip=0, exp_addr=0.
  - pf_ready is forced 0 while resetl=0.
- State:
  - 3-entry halfword FIFO; head drives op_data.
  - exp_addr: expected longword address, bits 1:0 held 0.
  - skip: discard upper half of the next accepted longword.
  - op_pc: PC of the head entry.
- op_valid = (buf_cnt != 0). op_data/op_pc are registered and stable while op_valid=1 and op_ready=0.
- pf_ready = resetl & (buf_cnt <= 1), decoded from registers only. There is no combinational path from op_ready or flush to pf_ready.
- pop = op_valid & op_ready & ~flush; accept = pf_valid & pf_ready & ~flush.
- On accept:
  - Match (pf_addr[AW-1:2] == exp_addr[AW-1:2]):
    - Push pf_data[31:16] then pf_data[15:0], or only pf_data[15:0] if skip=1.
    - Clear skip; exp_addr <= exp_addr + 4 (wraps to 0 at 2^AW).
  - Mismatch: nothing pushed, exp_addr and skip unchanged, stale=1 next cycle.
- On pop: head removed; op_pc <= op_pc + 2 (wraps modulo 2^AW).
- Pop and accept in the same cycle: both apply. The count after the cycle is buf_cnt - 1 + pushed. It never exceeds 3, because accept requires buf_cnt <= 1.
- Flush has highest priority and completes in 1 cycle:
  - Buffer cleared (buf_cnt=0, op_valid=0 next cycle).
  - op_pc <= {flush_pc[AW-1:1],0}; exp_addr <= {flush_pc[AW-1:2],00}; skip <= flush_pc[1].
  - A handshake on op_* or pf_* in the flush cycle is void: no pop, no push.
  - The prefetcher must re-send any longword it presented in that cycle.
- Empty: op_valid=0 and op_ready is ignored. Full (3): pf_ready=0.
- Reset during operation: all state returns to reset values on that edge, regardless of flush, pf_valid, or op_ready.

Test Plan:
- Reset then flush_pc=0x000100; push pf_addr=0x000100 data=0x12345678 → op 0x1234 @pc 0x000100, then 0x5678 @0x000102; buf_cnt 2→1→0.
- flush_pc=0x000202; push addr 0x000200 data 0xAAAABBBB → only 0xBBBB presented @0x000202; the next longword is expected at 0x000204.
- Stall: op_ready=0 with 2 entries → pf_ready=0 after buf_cnt reaches 2; op_data/op_pc hold; raise op_ready while pushing → back-to-back opcodes with no bubble and no overflow (buf_cnt ≤ 3).
- Stale: exp_addr=0x000300, push addr 0x000400 → dropped, stale pulses once, buf_cnt unchanged; next push at 0x000300 is accepted.
- Wrap: flush_pc=0x7FFFFC, push 0x7FFFFC then 0x000000 → op_pc sequence 0x7FFFFC, 0x7FFFFE, 0x000000, 0x000002.
- Flush with pf_valid=1 and op_ready=1 in the same cycle → buffer empty next cycle, nothing pushed or popped, op_pc equals flush_pc; resetl=0 mid-stream → all outputs zero and pf_ready=0.
